// File: rtl/ddt_pkg.sv
// ddt_pkg: shared FSM state encoding, WE_Cnt phase codes and default frame geometry
// for the DDT write-side controller (ddt_write_ctrl, ddt_edge_det).
package ddt_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, CAPTURE = 2'd2, PARK = 2'd3} ddt_state_e;
  localparam logic [1:0] WECNT_CLR  = 2'b00;
  localparam logic [1:0] WECNT_RUN  = 2'b01;
  localparam logic [1:0] WECNT_PARK = 2'b10;
  localparam int SOURCE_NUM_DEF = 1024;
  localparam int LINE_NUM_DEF   = 768;
endpackage

// File: rtl/ddt_write_ctrl_if.sv
// ddt_write_ctrl_if: DDT input bus plus SRAM write-side control outputs.
// master: DDT source side (drives DDT_VS/DDT_DE/DDT_Data/Frame_Req, observes controls).
// slave : ddt_write_ctrl (samples DDT inputs, drives EN/WE/WE_Cnt/pipeline/pulses).
interface ddt_write_ctrl_if #(parameter int DATA_W = 27);
  logic              DDT_VS;
  logic              DDT_DE;
  logic [DATA_W-1:0] DDT_Data;
  logic              Frame_Req;
  logic              EN;
  logic              WE;
  logic              WE_Delay2;
  logic [DATA_W-1:0] Data_IN_Delay2;
  logic              DDT_DE_Delay1;
  logic              Line_Change;
  logic              Addr_Jump;
  logic [15:0]       DDT_Line_Cnt;
  logic [1:0]        WE_Cnt;
  logic              Frame_Done;
  modport master (
    output DDT_VS, DDT_DE, DDT_Data, Frame_Req,
    input  EN, WE, WE_Delay2, Data_IN_Delay2, DDT_DE_Delay1, Line_Change, Addr_Jump,
           DDT_Line_Cnt, WE_Cnt, Frame_Done
  );
  modport slave (
    input  DDT_VS, DDT_DE, DDT_Data, Frame_Req,
    output EN, WE, WE_Delay2, Data_IN_Delay2, DDT_DE_Delay1, Line_Change, Addr_Jump,
           DDT_Line_Cnt, WE_Cnt, Frame_Done
  );
endinterface

// File: rtl/ddt_edge_det.sv
// ddt_edge_det: registered rise/fall detector on the falling edge of DDT_Clock.
// Ports: DDT_Clock, Reset (async, active-low), d (input level), q (d one cycle late),
// rise = d & !q, fall = !d & q.
module ddt_edge_det (
  input  logic DDT_Clock,
  input  logic Reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  always_ff @(negedge DDT_Clock or negedge Reset)
    if (!Reset) q <= 1'b0;
    else q <= d;
  assign rise = d & !q;
  assign fall = !d & q;
endmodule

// File: rtl/ddt_write_ctrl.sv
// ddt_write_ctrl: DDT capture front-end; registers pixels through a 2-stage pipeline and
// generates SRAM write-side control (EN/WE mode, WE_Cnt phase, line count, pulses).
// Ports: DDT_Clock (falling-edge clock), Reset (async, active-low), bus (ddt_write_ctrl_if.slave).
// Build option: DDT_CONT_CAPTURE_EN - when defined, PARK returns to WAIT_VS for continuous capture.
module ddt_write_ctrl
  import ddt_pkg::*;
#(
  parameter int SOURCE_NUM = SOURCE_NUM_DEF,
  parameter int LINE_NUM   = LINE_NUM_DEF,
  parameter int DATA_W     = 27,
  parameter int PARK_CYC   = 3
) (
  input logic DDT_Clock,
  input logic Reset,
  ddt_write_ctrl_if.slave bus
);
  localparam int PW = $clog2(PARK_CYC);
`ifdef DDT_CONT_CAPTURE_EN
  localparam ddt_state_e PARK_EXIT = WAIT_VS;
`else
  localparam ddt_state_e PARK_EXIT = IDLE;
`endif
  if (LINE_NUM < 1 || LINE_NUM > 65535 || PARK_CYC < 2 || SOURCE_NUM * LINE_NUM > (1 << 21)) begin : g_bad_cfg
    $error("ddt_write_ctrl: illegal SOURCE_NUM/LINE_NUM/PARK_CYC combination");
  end
  ddt_state_e state, nxt;
  logic vs_q, vs_rise, vs_fall, de_q, de_rise, de_fall;
  logic [DATA_W-1:0] data_d1, data_d2;
  logic de_d2, restart, frame_valid, line_change, addr_jump, frame_done;
  logic [15:0] line_cnt;
  logic [PW-1:0] park_cnt;
  logic en, we, cap, line_end, last_line, park_done, vs_restart;
  logic [1:0] we_cnt;
  logic unused_edges;
  ddt_edge_det u_vs (.DDT_Clock(DDT_Clock), .Reset(Reset), .d(bus.DDT_VS), .q(vs_q), .rise(vs_rise), .fall(vs_fall));
  ddt_edge_det u_de (.DDT_Clock(DDT_Clock), .Reset(Reset), .d(bus.DDT_DE), .q(de_q), .rise(de_rise), .fall(de_fall));
  assign unused_edges = ^{vs_q, vs_fall, de_rise};
  // A VS rise in CAPTURE restarts the frame and swallows a coincident line end.
  assign vs_restart = state == CAPTURE && vs_rise;
  assign line_end   = state == CAPTURE && de_fall && !vs_rise;
  assign last_line  = line_cnt == 16'(LINE_NUM - 1);
  assign park_done  = state == PARK && park_cnt == PW'(PARK_CYC - 1);
  assign cap        = state == CAPTURE || state == PARK;
  always_ff @(negedge DDT_Clock or negedge Reset)
    if (!Reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt    = state;
    en     = 1'b0;
    we     = 1'b0;
    we_cnt = WECNT_CLR;
    case (state)
      IDLE: begin
        nxt = bus.Frame_Req ? WAIT_VS : IDLE;
        en  = !frame_valid;
        we  = 1'b1;
      end
      WAIT_VS: nxt = vs_rise ? CAPTURE : WAIT_VS;
      CAPTURE: begin
        nxt    = line_end && last_line ? PARK : CAPTURE;
        we_cnt = restart ? WECNT_CLR : WECNT_RUN;
      end
      PARK: begin
        nxt    = park_done ? PARK_EXIT : PARK;
        we_cnt = WECNT_PARK;
      end
    endcase
  end
  always_ff @(negedge DDT_Clock or negedge Reset)
    if (!Reset) begin
      data_d1     <= '0;
      data_d2     <= '0;
      de_d2       <= 1'b0;
      restart     <= 1'b0;
      line_change <= 1'b0;
      addr_jump   <= 1'b0;
      frame_done  <= 1'b0;
      line_cnt    <= '0;
      park_cnt    <= '0;
      frame_valid <= 1'b0;
    end else begin
      data_d1     <= bus.DDT_Data;
      data_d2     <= data_d1;
      de_d2       <= de_q;
      restart     <= vs_restart;
      line_change <= line_end;
      addr_jump   <= line_change && line_cnt < 16'(LINE_NUM);
      frame_done  <= line_end && last_line;
      line_cnt    <= nxt == WAIT_VS || vs_restart ? '0 : line_end ? line_cnt + 16'd1 : line_cnt;
      park_cnt    <= state == PARK ? park_cnt + 1'b1 : '0;
      frame_valid <= frame_valid | park_done;
    end
  assign bus.EN             = en;
  assign bus.WE             = we;
  assign bus.WE_Cnt         = we_cnt;
  assign bus.Data_IN_Delay2 = data_d2;
  assign bus.DDT_DE_Delay1  = de_q & cap;
  assign bus.WE_Delay2      = de_d2 & cap;
  assign bus.Line_Change    = line_change;
  assign bus.Addr_Jump      = addr_jump;
  assign bus.DDT_Line_Cnt   = line_cnt;
  assign bus.Frame_Done     = frame_done;
endmodule

// File: tb/tb_ddt_write_ctrl.sv
// tb_ddt_write_ctrl: directed self-checking bench for ddt_write_ctrl (LINE_NUM=4, SOURCE_NUM=8).
module tb_ddt_write_ctrl;
  logic clk = 1'b0;
  logic Reset;
  int errors = 0, checks = 0;
  int lc_n, aj_n, fd_n, w2_n, pk_n, aj_bad, dat_bad, we_hi, en_hi;
  int data_cnt = 0;
  logic lc_prev = 1'b0;
  logic [26:0] d_prev = '0;
  ddt_write_ctrl_if #(.DATA_W(27)) bus ();
  ddt_write_ctrl #(.SOURCE_NUM(8), .LINE_NUM(4), .DATA_W(27), .PARK_CYC(3)) dut (
    .DDT_Clock(clk), .Reset(Reset), .bus(bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    lc_n = 0; aj_n = 0; fd_n = 0; w2_n = 0; pk_n = 0; aj_bad = 0; dat_bad = 0; we_hi = 0; en_hi = 0;
  endtask
  // Drive one cycle of inputs, let the falling edge sample them, then tally outputs.
  task automatic tick(input logic vs, input logic de);
    data_cnt++;
    bus.DDT_VS   = vs;
    bus.DDT_DE   = de;
    bus.DDT_Data = 27'(data_cnt);
    @(negedge clk);
    #2;
    lc_n += int'(bus.Line_Change);
    aj_n += int'(bus.Addr_Jump);
    fd_n += int'(bus.Frame_Done);
    w2_n += int'(bus.WE_Delay2);
    pk_n += int'(bus.WE_Cnt == 2'b10);
    we_hi += int'(bus.WE);
    en_hi += int'(bus.EN);
    if (bus.Addr_Jump && !lc_prev) aj_bad++;
    if (bus.Data_IN_Delay2 !== d_prev) dat_bad++;
    lc_prev = bus.Line_Change;
    d_prev  = bus.DDT_Data;
  endtask
  task automatic line(input int n);
    repeat (8) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk($sformatf("lc_line%0d", n), bus.Line_Change, 1);
    chk($sformatf("cnt_line%0d", n), bus.DDT_Line_Cnt, n);
    chk($sformatf("fd_line%0d", n), bus.Frame_Done, n == 4);
    tick(1'b0, 1'b0);
    chk($sformatf("aj_line%0d", n), bus.Addr_Jump, n < 4);
    if (n == 4) chk("park_wecnt", bus.WE_Cnt, 2'b10);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask
  task automatic start_frame();
    bus.Frame_Req = 1'b1;
    tick(1'b0, 1'b0);
    bus.Frame_Req = 1'b0;
    tick(1'b1, 1'b0);
  endtask
  initial begin
    Reset = 1'b0;
    bus.Frame_Req = 1'b0;
    bus.DDT_VS = 1'b0;
    bus.DDT_DE = 1'b0;
    bus.DDT_Data = '0;
    clr();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    chk("rst_EN", bus.EN, 1);
    chk("rst_WE", bus.WE, 1);
    chk("rst_WE_Cnt", bus.WE_Cnt, 0);
    chk("rst_cnt", bus.DDT_Line_Cnt, 0);
    chk("rst_fd", bus.Frame_Done, 0);
    Reset = 1'b1;
    clr();
    repeat (100) tick(1'b0, 1'b0);
    chk("idle_fd_n", fd_n, 0);
    chk("idle_we_hi", we_hi, 100);
    chk("idle_en_hi", en_hi, 100);
    chk("idle_WE_Cnt", bus.WE_Cnt, 0);
    // Frame 1: data counts up from 1 starting with the request cycle.
    data_cnt = 0;
    clr();
    bus.Frame_Req = 1'b1;
    tick(1'b0, 1'b0);
    bus.Frame_Req = 1'b0;
    chk("wait_WE", bus.WE, 0);
    chk("wait_EN", bus.EN, 0);
    chk("wait_WE_Cnt", bus.WE_Cnt, 0);
    tick(1'b1, 1'b0);
    chk("cap_WE_Cnt", bus.WE_Cnt, 1);
    chk("data_d2_first", bus.Data_IN_Delay2, 1);
    for (int l = 1; l <= 4; l++) line(l);
    chk("f1_lc_n", lc_n, 4);
    chk("f1_aj_n", aj_n, 3);
    chk("f1_aj_order", aj_bad, 0);
    chk("f1_fd_n", fd_n, 1);
    chk("f1_we_delay2", w2_n, 32);
    chk("f1_park_cyc", pk_n, 3);
    chk("f1_data_pipe", dat_bad, 0);
    chk("f1_end_cnt", bus.DDT_Line_Cnt, 4);
    chk("f1_end_EN", bus.EN, 0);
`ifdef DDT_CONT_CAPTURE_EN
    chk("f1_end_WE", bus.WE, 0);
`else
    chk("f1_end_WE", bus.WE, 1);
`endif
    // Short frame: VS in the gap after line 2, then VS coinciding with a DE fall.
    clr();
    start_frame();
    line(1);
    line(2);
    tick(1'b1, 1'b0);
    chk("rs_WE_Cnt", bus.WE_Cnt, 0);
    chk("rs_cnt", bus.DDT_Line_Cnt, 0);
    tick(1'b0, 1'b0);
    chk("rs_run", bus.WE_Cnt, 1);
    repeat (8) tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    chk("rs2_lc", bus.Line_Change, 0);
    chk("rs2_cnt", bus.DDT_Line_Cnt, 0);
    chk("rs2_WE_Cnt", bus.WE_Cnt, 0);
    tick(1'b0, 1'b0);
    for (int l = 1; l <= 4; l++) line(l);
    chk("rs_fd_n", fd_n, 1);
    chk("rs_lc_n", lc_n, 6);
    chk("rs_aj_n", aj_n, 5);
`ifdef DDT_CONT_CAPTURE_EN
    clr();
    for (int f = 0; f < 3; f++) begin
      tick(1'b1, 1'b0);
      for (int l = 1; l <= 4; l++) line(l);
    end
    chk("cont_fd_n", fd_n, 3);
    chk("cont_we_hi", we_hi, 0);
    chk("cont_lc_n", lc_n, 12);
`endif
    // Reset in the middle of line 3.
    start_frame();
    line(1);
    line(2);
    repeat (4) tick(1'b0, 1'b1);
    chk("pre_rst_de1", bus.DDT_DE_Delay1, 1);
    #1 Reset = 1'b0;
    #1;
    chk("mid_rst_EN", bus.EN, 1);
    chk("mid_rst_WE", bus.WE, 1);
    chk("mid_rst_WE_Cnt", bus.WE_Cnt, 0);
    chk("mid_rst_cnt", bus.DDT_Line_Cnt, 0);
    chk("mid_rst_de1", bus.DDT_DE_Delay1, 0);
    chk("mid_rst_we2", bus.WE_Delay2, 0);
    chk("mid_rst_data", bus.Data_IN_Delay2, 0);
    tick(1'b0, 1'b1);
    Reset = 1'b1;
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    chk("post_rst_EN", bus.EN, 1);
    chk("post_rst_WE", bus.WE, 1);
    chk("post_rst_WE_Cnt", bus.WE_Cnt, 0);
    chk("post_rst_lc", bus.Line_Change, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ddt_write_ctrl.md
Name: ddt_write_ctrl

Overview:
- DDT input front-end on the DDT_Clock domain. Feeds the SRAM frame-buffer / RGB output stage directly downstream.
- Captures one DDT frame per request and registers the pixel data through a 2-stage pipeline.
- Generates all write-side control: EN/WE mode select, write-address phase (WE_Cnt), line counter, line-change and address-jump pulses.
- Hands the SRAM back to read mode after the frame's last write has drained.

Parameters:
- SOURCE_NUM, 1024, pixels (SRAM words) per line; must equal the downstream Source_Num constant.
- LINE_NUM, 768, lines per frame; legal range 1..65535; SOURCE_NUM*LINE_NUM ≤ 2^21.
- DATA_W, 27, DDT pixel word width.
- PARK_CYC, 3, DDT_Clock cycles spent in PARK before returning to IDLE; minimum 2.

Ports:
- DDT_Clock  in  1  DDT pixel clock; all flops update on its falling edge.
- Reset  in  1  asynchronous, active-low.
- DDT_VS  in  1  frame sync, active high.
- DDT_DE  in  1  DDT data enable, active high for the whole active line.
- DDT_Data  in  DATA_W  pixel word.
- Frame_Req  in  1  capture request, level-sampled in IDLE.
- EN  out  1  SRAM mode-change enable, active low.
- WE  out  1  0 = write mode (DDT clock), 1 = read mode.
- WE_Delay2  out  1  DDT_DE delayed 2 cycles, gated by CAPTURE.
- Data_IN_Delay2  out  DATA_W  DDT_Data delayed 2 cycles.
- DDT_DE_Delay1  out  1  DDT_DE delayed 1 cycle, gated by CAPTURE.
- Line_Change  out  1  1-cycle pulse at the end of each active line.
- Addr_Jump  out  1  1-cycle pulse the cycle after Line_Change.
- DDT_Line_Cnt  out  16  completed lines in the current frame.
- WE_Cnt  out  2  write-address phase: 00 clear, 01 run, 10 park.
- Frame_Done  out  1  1-cycle pulse when a full frame has been captured.

Behaviour:
- Reset values: EN=1, WE=1, WE_Cnt=00, all other outputs 0, state=IDLE, frame-valid flag=0. Reset asserted mid-frame returns to these values immediately; no partial-frame completion.
- Edge detection: registered copies of DDT_VS and DDT_DE.
  - VS_rise = DDT_VS & !VS_q.
  - DE_fall = !DDT_DE & DE_q.
- Data pipeline runs in all states:
  - Data_IN_Delay2 = DDT_Data two falling edges earlier.
  - DDT_DE_Delay1 and WE_Delay2 are forced to 0 outside CAPTURE/PARK.
- IDLE:
  - Outputs: WE=1, WE_Cnt=00; EN = !frame-valid, so read mode is requested only after the first completed frame.
  - Frame_Req=1 → WAIT_VS.
- WAIT_VS:
  - Outputs: EN=0, WE=0, WE_Cnt=00 (downstream address held at 0), DDT_Line_Cnt=0.
  - VS_rise → CAPTURE.
- CAPTURE:
  - Outputs: EN=0, WE=0, WE_Cnt=01.
  - DE_fall → Line_Change=1 for 1 cycle and DDT_Line_Cnt += 1 on the same edge.
  - If the new count < LINE_NUM: Addr_Jump=1 on the following cycle.
  - If the new count == LINE_NUM: no Addr_Jump; go to PARK and pulse Frame_Done.
  - VS_rise inside CAPTURE (short frame): WE_Cnt=00 for exactly 1 cycle, DDT_Line_Cnt=0, stay in CAPTURE (restart at address 0). No Frame_Done.
  - DE_fall and VS_rise in the same cycle: VS_rise wins; the line is not counted.
- PARK:
  - Outputs: WE=0, WE_Cnt=10.
  - Lasts PARK_CYC cycles so the 2 pipelined words drain.
  - Then → IDLE and set frame-valid=1.
  - DDT_Line_Cnt holds at LINE_NUM until the next WAIT_VS.
- Frame_Req deasserted during WAIT_VS/CAPTURE: ignored; the current frame completes.
- DDT_Line_Cnt never exceeds LINE_NUM; DE_fall events in PARK/IDLE are ignored.

Optional Feature:
- Macro DDT_CONT_CAPTURE_EN.
  - Defined: PARK → WAIT_VS directly (continuous capture, Frame_Req ignored after the first frame); EN stays 0 and WE stays 0.
  - Undefined: single-shot per Frame_Req as described above.

Decomposition:
- Shared package ddt_pkg:
  - state encoding IDLE/WAIT_VS/CAPTURE/PARK;
  - WE_Cnt codes WECNT_CLR=2'b00, WECNT_RUN=2'b01, WECNT_PARK=2'b10;
  - default SOURCE_NUM and LINE_NUM.
- One sub-module: ddt_edge_det (registered rise/fall detector, falling-edge clocked, async active-low reset), instantiated for VS and DE.

Test Plan:
- Reset then hold Frame_Req=0 for 100 cycles → EN=1, WE=1, WE_Cnt=00, Frame_Done never pulses.
- LINE_NUM=4, SOURCE_NUM=8, Frame_Req=1, one VS then 4 lines of 8 DE cycles with a 4-cycle gap:
  - 4 Line_Change pulses and 3 Addr_Jump pulses, each 1 cycle after its Line_Change;
  - DDT_Line_Cnt steps 1..4;
  - Frame_Done 1 cycle; WE_Cnt=10 for 3 cycles, then WE=1, EN=0.
- DDT_Data incrementing from 0x0000001 → Data_IN_Delay2 equals the input from 2 cycles earlier; WE_Delay2 is high for exactly 8 cycles per line.
- VS_rise after line 2 of 4 → WE_Cnt=00 for 1 cycle, DDT_Line_Cnt=0, no Frame_Done; the next 4 lines complete the frame normally.
- Reset deasserted-to-asserted during line 3 → all outputs at reset values within the same cycle; after release, state=IDLE.
- With DDT_CONT_CAPTURE_EN defined, 3 back-to-back frames → 3 Frame_Done pulses, WE stays 0 throughout, no IDLE visit.
